// File: rtl/ram_seq_if.sv
// Request/response bus between the memory controller and ram_seq.
interface ram_seq_if #(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned MAX_BYTES  = 4
);
  localparam int unsigned DW = 8 * MAX_BYTES;

  logic                  req_valid_in;
  logic                  req_ready_out;
  logic                  req_wr_in;
  logic [1:0]            req_size_in;
  logic                  req_signed_in;
  logic [ADDR_WIDTH-1:0] req_addr_in;
  logic [DW-1:0]         req_wdata_in;
  logic                  resp_valid_out;
  logic [DW-1:0]         resp_rdata_out;
  logic                  busy_out;

  // Controller side: issues requests, observes responses.
  modport master (
    output req_valid_in, req_wr_in, req_size_in, req_signed_in, req_addr_in, req_wdata_in,
    input  req_ready_out, resp_valid_out, resp_rdata_out, busy_out
  );

  // Memory side: accepts requests, produces responses.
  modport slave (
    input  req_valid_in, req_wr_in, req_size_in, req_signed_in, req_addr_in, req_wdata_in,
    output req_ready_out, resp_valid_out, resp_rdata_out, busy_out
  );
endinterface

// File: rtl/ram_seq.sv
// Byte-wide synchronous RAM behind a request/response port; multi-byte
// little-endian accesses are sequenced one byte per cycle.
module ram_seq #(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned MAX_BYTES  = 4
) (
  input  logic      clk_in,
  input  logic      rst_n_in,
  ram_seq_if.slave  bus
);
  localparam int unsigned DW      = 8 * MAX_BYTES;
  localparam int unsigned DEPTH   = 2 ** ADDR_WIDTH;
  localparam int unsigned MAX_LOG = $clog2(MAX_BYTES);
  localparam int unsigned CW      = (MAX_LOG == 0) ? 1 : MAX_LOG;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DRAIN  = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wr_q, wr_d;
  logic                  sgn_q, sgn_d;
  logic [CW-1:0]         last_q, last_d;     // byte count minus one
  logic [CW-1:0]         cnt_q, cnt_d;       // current byte index in ACCESS
  logic [DW-1:0]         wdata_q, wdata_d;
  logic [DW-1:0]         acc_q, acc_d;       // read result being assembled
  logic                  cap_q, cap_d;       // storage output holds a byte to capture
  logic [CW-1:0]         lane_q, lane_d;     // lane that byte belongs to
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DW-1:0]         resp_rdata_q, resp_rdata_d;

  logic                  mem_we_c;
  logic [ADDR_WIDTH-1:0] mem_addr_c;
  logic [7:0]            mem_wdata_c;
  logic [7:0]            mem_rdata_q;
  logic [7:0]            mem_q [DEPTH];

  logic [1:0]            size_cl;

  // Fill lanes above the accessed bytes with zero or the sign of the top byte.
  function automatic logic [DW-1:0] extend(input logic [DW-1:0] v,
                                           input logic [CW-1:0] last,
                                           input logic          sg);
    logic [DW-1:0] r;
    logic          fill;
    r    = v;
    fill = sg & v[{last, 3'b111}];
    for (int unsigned l = 0; l < MAX_BYTES; l++) begin
      if (l > 32'(last)) r[8*l +: 8] = {8{fill}};
    end
    return r;
  endfunction

  // Single-port storage, read-first; contents deliberately not reset.
  always_ff @(posedge clk_in) begin
    if (mem_we_c) mem_q[mem_addr_c] <= mem_wdata_c;
    mem_rdata_q <= mem_q[mem_addr_c];
  end

  // FSM state register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Datapath and output registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      addr_q       <= '0;
      wr_q         <= 1'b0;
      sgn_q        <= 1'b0;
      last_q       <= '0;
      cnt_q        <= '0;
      wdata_q      <= '0;
      acc_q        <= '0;
      cap_q        <= 1'b0;
      lane_q       <= '0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      addr_q       <= addr_d;
      wr_q         <= wr_d;
      sgn_q        <= sgn_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      wdata_q      <= wdata_d;
      acc_q        <= acc_d;
      cap_q        <= cap_d;
      lane_q       <= lane_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Next-state, byte sequencing and storage control.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wr_d         = wr_q;
    sgn_d        = sgn_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    wdata_d      = wdata_q;
    acc_d        = acc_q;
    cap_d        = 1'b0;
    lane_d       = lane_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    mem_we_c     = 1'b0;
    mem_addr_c   = addr_q + ADDR_WIDTH'(cnt_q);
    mem_wdata_c  = wdata_q[{cnt_q, 3'b000} +: 8];
    size_cl      = bus.req_size_in;
    if (bus.req_size_in > 2'(MAX_LOG)) size_cl = 2'(MAX_LOG);

    // Byte read in the previous cycle lands in its result lane.
    if (cap_q) acc_d[{lane_q, 3'b000} +: 8] = mem_rdata_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid_in) begin
          addr_d  = bus.req_addr_in;
          wr_d    = bus.req_wr_in;
          sgn_d   = bus.req_signed_in;
          last_d  = CW'((32'd1 << size_cl) - 32'd1);
          wdata_d = bus.req_wdata_in;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        mem_we_c = wr_q;
        if (!wr_q) begin
          cap_d  = 1'b1;
          lane_d = cnt_q;
        end
        if (cnt_q == last_q) state_d = wr_q ? RESP : DRAIN;
        else                 cnt_d   = cnt_q + CW'(1);
      end
      DRAIN:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Response is registered on entry to RESP and cleared afterwards.
    if (state_d == RESP && state_q != RESP) begin
      resp_valid_d = 1'b1;
      resp_rdata_d = wr_q ? '0 : extend(acc_d, last_q, sgn_q);
    end
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  assign bus.req_ready_out  = ready_q;
  assign bus.busy_out       = busy_q;
  assign bus.resp_valid_out = resp_valid_q;
  assign bus.resp_rdata_out = resp_rdata_q;

endmodule

// File: tb/tb_ram_seq.sv
// Directed bench for ram_seq: latency, data, sign/clamp, wrap, handshake, reset.
module tb_ram_seq;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ram_seq_if #(.ADDR_WIDTH(17), .MAX_BYTES(4)) bus ();
  ram_seq #(.ADDR_WIDTH(17), .MAX_BYTES(4)) dut (.clk_in(clk), .rst_n_in(rst_n), .bus(bus));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request: waits for the response with a bounded cycle budget.
  task automatic xfer(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                      input logic [16:0] a, input logic [31:0] wd,
                      input int exp_lat, input logic [31:0] exp_rd);
    int          lat;
    logic [31:0] rd;
    @(negedge clk);
    bus.req_valid_in  = 1'b1;
    bus.req_wr_in     = wr;
    bus.req_size_in   = sz;
    bus.req_signed_in = sg;
    bus.req_addr_in   = a;
    bus.req_wdata_in  = wd;
    @(negedge clk);
    bus.req_valid_in  = 1'b0;
    bus.req_addr_in   = ~a;
    bus.req_wdata_in  = ~wd;
    bus.req_signed_in = ~sg;
    lat = 0;
    rd  = '0;
    for (int c = 1; c <= 20; c++) begin
      if (bus.resp_valid_out) begin
        lat = c;
        rd  = bus.resp_rdata_out;
        break;
      end
      @(negedge clk);
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " rdata"}, 64'(rd), 64'(exp_rd));
    check({tag, " ready during resp"}, 64'(bus.req_ready_out), 64'd0);
  endtask

  initial begin
    int pulses;
    int accepts;
    bus.req_valid_in  = 1'b0;
    bus.req_wr_in     = 1'b0;
    bus.req_size_in   = 2'd0;
    bus.req_signed_in = 1'b0;
    bus.req_addr_in   = '0;
    bus.req_wdata_in  = '0;

    // Reset then idle
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset ready", 64'(bus.req_ready_out), 64'd1);
    check("reset busy", 64'(bus.busy_out), 64'd0);
    check("reset resp_valid", 64'(bus.resp_valid_out), 64'd0);
    check("reset rdata", 64'(bus.resp_rdata_out), 64'd0);

    // Word round trip
    xfer("wr word", 1'b1, 2'd2, 1'b0, 17'h00100, 32'hDEADBEEF, 5, 32'h0);
    check("busy in resp", 64'(bus.busy_out), 64'd1);
    @(negedge clk);
    check("post-resp valid", 64'(bus.resp_valid_out), 64'd0);
    check("post-resp rdata", 64'(bus.resp_rdata_out), 64'd0);
    check("post-resp ready", 64'(bus.req_ready_out), 64'd1);
    xfer("rd word", 1'b0, 2'd2, 1'b0, 17'h00100, 32'h0, 6, 32'hDEADBEEF);
    @(negedge clk);
    check("rdata clears after read", 64'(bus.resp_rdata_out), 64'd0);
    xfer("rd byte 101", 1'b0, 2'd0, 1'b0, 17'h00101, 32'h0, 3, 32'h000000BE);
    xfer("rd half signed", 1'b0, 2'd1, 1'b1, 17'h00100, 32'h0, 4, 32'hFFFFBEEF);

    // Sign and clamp
    xfer("wr byte 80", 1'b1, 2'd0, 1'b0, 17'h00010, 32'h00000080, 2, 32'h0);
    xfer("rd byte signed", 1'b0, 2'd0, 1'b1, 17'h00010, 32'h0, 3, 32'hFFFFFF80);
    xfer("rd byte unsigned", 1'b0, 2'd0, 1'b0, 17'h00010, 32'h0, 3, 32'h00000080);
    xfer("rd size3 clamp", 1'b0, 2'd3, 1'b1, 17'h00100, 32'h0, 6, 32'hDEADBEEF);

    // Wrap-around at the top of storage
    xfer("wr wrap", 1'b1, 2'd2, 1'b0, 17'h1FFFE, 32'h44332211, 5, 32'h0);
    xfer("rd 1FFFE", 1'b0, 2'd0, 1'b0, 17'h1FFFE, 32'h0, 3, 32'h11);
    xfer("rd 1FFFF", 1'b0, 2'd0, 1'b0, 17'h1FFFF, 32'h0, 3, 32'h22);
    xfer("rd 00000", 1'b0, 2'd0, 1'b0, 17'h00000, 32'h0, 3, 32'h33);
    xfer("rd 00001", 1'b0, 2'd0, 1'b0, 17'h00001, 32'h0, 3, 32'h44);
    xfer("rd wrap word", 1'b0, 2'd2, 1'b0, 17'h1FFFE, 32'h0, 6, 32'h44332211);

    // Handshake with req_valid held high and inputs changing every cycle
    xfer("clr 300", 1'b1, 2'd2, 1'b0, 17'h00300, 32'h0, 5, 32'h0);
    xfer("clr 304", 1'b1, 2'd2, 1'b0, 17'h00304, 32'h0, 5, 32'h0);
    xfer("clr 308", 1'b1, 2'd2, 1'b0, 17'h00308, 32'h0, 5, 32'h0);
    @(negedge clk);
    pulses  = 0;
    accepts = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.resp_valid_out) pulses++;
      if (bus.req_ready_out) accepts++;
      bus.req_valid_in  = 1'b1;
      bus.req_wr_in     = 1'b1;
      bus.req_size_in   = 2'd0;
      bus.req_signed_in = 1'b0;
      bus.req_addr_in   = 17'h00300 + 17'(i);
      bus.req_wdata_in  = 32'h10 + 32'(i);
      @(negedge clk);
    end
    bus.req_valid_in = 1'b0;
    check("hs accepts", 64'(accepts), 64'd4);
    check("hs resp pulses", 64'(pulses), 64'd4);
    xfer("hs rd 300", 1'b0, 2'd2, 1'b0, 17'h00300, 32'h0, 6, 32'h13000010);
    xfer("hs rd 304", 1'b0, 2'd2, 1'b0, 17'h00304, 32'h0, 6, 32'h00160000);
    xfer("hs rd 308", 1'b0, 2'd2, 1'b0, 17'h00308, 32'h0, 6, 32'h00001900);

    // Reset during the third byte of a word write
    xfer("clr 200", 1'b1, 2'd2, 1'b0, 17'h00200, 32'h0, 5, 32'h0);
    @(negedge clk);
    bus.req_valid_in  = 1'b1;
    bus.req_wr_in     = 1'b1;
    bus.req_size_in   = 2'd2;
    bus.req_signed_in = 1'b0;
    bus.req_addr_in   = 17'h00200;
    bus.req_wdata_in  = 32'hAABBCCDD;
    @(negedge clk);
    bus.req_valid_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst busy", 64'(bus.busy_out), 64'd0);
    check("midrst ready", 64'(bus.req_ready_out), 64'd1);
    check("midrst resp_valid", 64'(bus.resp_valid_out), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.resp_valid_out) pulses++;
    end
    check("midrst no resp", 64'(pulses), 64'd0);
    xfer("midrst readback", 1'b0, 2'd2, 1'b0, 17'h00200, 32'h0, 6, 32'h0000CCDD);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ram_seq.md
# ram_seq

Parametrised, handshaked successor to the team's byte-wide on-board RAM. It holds 2**ADDR_WIDTH bytes of synchronous single-port storage behind a request/response interface. It serves 1-, 2-, 4- or 8-byte little-endian accesses by sequencing one byte per cycle internally. It sits between the CPU memory controller and on-board storage, so the controller issues whole-word loads and stores instead of driving byte strobes.

## Interface
- ADDR_WIDTH, 17: byte-address width; storage is 2**ADDR_WIDTH bytes.
- MAX_BYTES, 4: widest access in bytes; legal values are 1, 2, 4, 8. Data buses are 8*MAX_BYTES wide.

Ports:
- clk_in  input  1  system clock; all state changes on the rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- req_valid_in  input  1  request present.
- req_ready_out  output  1  block can accept a request; high exactly when the state is IDLE.
- req_wr_in  input  1  1 = write, 0 = read.
- req_size_in  input  2  access is 2**req_size_in bytes, clamped to MAX_BYTES.
- req_signed_in  input  1  reads only: sign-extend from the top byte accessed.
- req_addr_in  input  ADDR_WIDTH  byte address of the lowest byte.
- req_wdata_in  input  8*MAX_BYTES  write data; byte k goes to address addr+k.
- resp_valid_out  output  1  one-cycle pulse marking completion of a request.
- resp_rdata_out  output  8*MAX_BYTES  read data; valid while resp_valid_out=1 after a read, 0 after a write.
- busy_out  output  1  high when the state is not IDLE.

## Operation
- States and transitions:
  - IDLE → ACCESS on a handshake (req_valid_in & req_ready_out).
  - ACCESS lasts N cycles, where N is the clamped byte count.
  - After ACCESS, a write goes to RESP; a read goes to DRAIN, then RESP.
  - RESP → IDLE.
- At acceptance the block latches addr, wr, signed, N and wdata. Request inputs are don't-care after acceptance.
- ACCESS cycle k (k = 0..N-1):
  - The storage address is (addr+k) mod 2**ADDR_WIDTH, so accesses wrap from the top address to 0.
  - Write: byte k of wdata is committed at the end of cycle k.
  - Read: storage data for byte k appears the following cycle. It is captured into result byte lane k at the end of that cycle. DRAIN captures the last byte.
- Read result bytes at lanes ≥ N are 0 when req_signed_in=0. When req_signed_in=1 they are copies of bit 7 of byte N-1.
- Only one request is outstanding at a time. A read following a write always returns the written data; there is no forwarding hazard.
- Storage contents are not initialised or cleared by reset.
- Reset asserted mid-request:
  - State goes to IDLE and all registers clear immediately.
  - Write bytes already committed stay in storage; the remaining bytes are never written.
  - No response is produced.
- Reset values:
  - req_ready_out=1, since the state is IDLE.
  - resp_valid_out=0, resp_rdata_out=0, busy_out=0.
  - Internal write enable is 0, so reset never corrupts storage.

## Timing
- E0 is the accepting edge.
- Write: resp_valid_out is high in cycle N+1 after E0. Examples: 1 byte → 2 cycles, 4 bytes → 5 cycles.
- Read: resp_valid_out is high in cycle N+2 after E0, for example 6 cycles for 4 bytes.
- req_ready_out rises in the cycle after RESP. The earliest back-to-back acceptance is that cycle's end edge, so a 1-byte write has a throughput of one request per 3 cycles.
- resp_rdata_out is registered and stable for the whole RESP cycle. It returns to 0 in the cycle after RESP.
- resp_valid_out never coincides with req_ready_out=1.

## Test plan
- Reset then idle: hold rst_n_in=0 for 3 cycles, release → req_ready_out=1, busy_out=0, resp_valid_out=0, resp_rdata_out=0.
- Word round trip: write size=2, addr=0x00100, wdata=0xDEADBEEF → resp 5 cycles after acceptance. Then read size=2 at 0x00100 → resp 6 cycles after acceptance with rdata=0xDEADBEEF. A byte read at 0x00101 returns 0x000000BE.
- Sign and clamp: store byte 0x80 at 0x00010, read it with size=0 and signed=1 → 0xFFFFFF80. Reading with signed=0 → 0x00000080. A read with size=3 and MAX_BYTES=4 behaves as a 4-byte read.
- Wrap-around: write size=2 at 0x1FFFE, wdata=0x44332211 → storage 0x1FFFE=0x11, 0x1FFFF=0x22, 0x00000=0x33, 0x00001=0x44. Reading back at 0x1FFFE returns 0x44332211.
- Handshake: hold req_valid_in=1 continuously with changing addr/wdata → accepted only in IDLE cycles. Inputs changed during ACCESS have no effect, and exactly one resp_valid_out pulse occurs per acceptance.
- Reset mid-write: preload 0x00200..0x00203 with 0x00. Write 0xAABBCCDD there and assert rst_n_in after two ACCESS cycles → no resp_valid_out. Readback returns 0x0000CCDD.
